// File: rtl/burst_clk_sched.sv
// Burst clock scheduler: grants one of two serial clock channels per frame (round-robin),
// waits for c4, then emits a programmed number of registered clock pulses on that channel.
module burst_clk_sched #(
  parameter int         HALF_PER = 2,
  parameter int         TIMEOUT  = 1023,
  parameter logic [7:0] LEN_RST  = 8'd32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       f0,
  input  logic       c4,
  input  logic [1:0] req,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic       clk_en1,
  output logic       clk_en2,
  output logic       clk1,
  output logic       clk2,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] frame_cnt
);

  localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HP_LAST  = HW'(HALF_PER - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_C4, BURST_HI, BURST_LO, DONE} state_t;

  state_t        state, state_nx;
  logic [2:0]    f0_sy, c4_sy;
  logic          f0_fall, c4_fall;
  logic          gnt, gnt_nx;        // 0 = ch1, 1 = ch2
  logic          rr, rr_nx;          // 0 = ch1 wins next tie
  logic [HW-1:0] hp_cnt, hp_nx;
  logic [8:0]    pulse_cnt, pc_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic [7:0]    burst_len, len_nx;
  logic [7:0]    fc_nx;
  logic          err_nx;
  logic [8:0]    len_ext;
  logic          en_nx;

  // [2] is the previous synced sample, so the edge strobe lands 3 cycles after the pin
  assign f0_fall = f0_sy[2] & ~f0_sy[1];
  assign c4_fall = c4_sy[2] & ~c4_sy[1];
  assign len_ext = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    rr_nx    = rr;
    hp_nx    = hp_cnt;
    pc_nx    = pulse_cnt;
    tmo_nx   = tmo_cnt;
    len_nx   = burst_len;
    err_nx   = err;
    fc_nx    = frame_cnt;
    case (state)
      IDLE: begin
        if (wr) begin
          len_nx = wdata;
          err_nx = 1'b0;
        end
        if (f0_fall && req != 2'b00) begin
          state_nx = WAIT_C4;
          tmo_nx   = '0;
          case (req)
            2'b01:   gnt_nx = 1'b0;
            2'b10:   gnt_nx = 1'b1;
            default: begin
              gnt_nx = rr;
              rr_nx  = ~rr;
            end
          endcase
        end
      end
      WAIT_C4: begin
        if (c4_fall) begin
          state_nx = BURST_HI;
          hp_nx    = '0;
          pc_nx    = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
      BURST_HI: begin
        if (hp_cnt == HP_LAST) begin
          state_nx = BURST_LO;
          hp_nx    = '0;
        end else begin
          hp_nx = hp_cnt + 1'b1;
        end
      end
      BURST_LO: begin
        if (hp_cnt == HP_LAST) begin
          hp_nx = '0;
          pc_nx = pulse_cnt + 9'd1;
          if (pc_nx == len_ext) begin
            state_nx = DONE;
            fc_nx    = frame_cnt + 8'd1;
          end else begin
            state_nx = BURST_HI;
          end
        end else begin
          hp_nx = hp_cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // overrun: a frame arrived while a transaction was still in flight
    if (f0_fall && state != IDLE) err_nx = 1'b1;
    en_nx = (state_nx == WAIT_C4) || (state_nx == BURST_HI) || (state_nx == BURST_LO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f0_sy <= '0;
      c4_sy <= '0;
    end else begin
      f0_sy <= {f0_sy[1:0], f0};
      c4_sy <= {c4_sy[1:0], c4};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rr        <= 1'b0;
      hp_cnt    <= '0;
      pulse_cnt <= '0;
      tmo_cnt   <= '0;
      burst_len <= LEN_RST;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      rr        <= rr_nx;
      hp_cnt    <= hp_nx;
      pulse_cnt <= pc_nx;
      tmo_cnt   <= tmo_nx;
      burst_len <= len_nx;
      err       <= err_nx;
      frame_cnt <= fc_nx;
    end
  end

  // outputs registered from next-state so they line up with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_en1 <= 1'b0;
      clk_en2 <= 1'b0;
      clk1    <= 1'b0;
      clk2    <= 1'b0;
      done    <= 1'b0;
    end else begin
      clk_en1 <= en_nx & ~gnt_nx;
      clk_en2 <= en_nx &  gnt_nx;
      clk1    <= (state_nx == BURST_HI) & ~gnt_nx;
      clk2    <= (state_nx == BURST_HI) &  gnt_nx;
      done    <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_burst_clk_sched.sv
// Directed bench for burst_clk_sched: expected bursts are queued at stimulus time and
// checked by a monitor against pulse counts, widths and frame_cnt on each done pulse.
module tb_burst_clk_sched;

  localparam int HP = 2;

  logic       clk, reset_n, f0, c4, wr;
  logic [1:0] req;
  logic [7:0] wdata;
  logic       clk_en1, clk_en2, clk1, clk2, busy, done, err;
  logic [7:0] frame_cnt;

  burst_clk_sched #(.HALF_PER(HP), .TIMEOUT(1023), .LEN_RST(8'd32)) dut (
    .clk(clk), .reset_n(reset_n), .f0(f0), .c4(c4), .req(req), .wr(wr), .wdata(wdata),
    .clk_en1(clk_en1), .clk_en2(clk_en2), .clk1(clk1), .clk2(clk2),
    .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int ch; int n; int fc; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int fcm = 0;
  int cnt1, cnt2, hr, lr;
  logic p1, p2, pany;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      cnt1 = 0; cnt2 = 0; hr = 0; lr = 0;
      p1 = 1'b0; p2 = 1'b0; pany = 1'b0;
    end else begin
      check("enable_overlap", int'(clk_en1 & clk_en2), 0);
      check("clk_without_en", int'((clk1 & ~clk_en1) | (clk2 & ~clk_en2)), 0);
      if ((clk1 | clk2) && !pany) begin
        if (cnt1 + cnt2 > 0) check("low_width", lr, HP);
        hr = 0;
      end
      if (!(clk1 | clk2) && pany) begin
        check("high_width", hr, HP);
        lr = 0;
      end
      if (clk1 | clk2) hr++; else lr++;
      if (clk1 && !p1) cnt1++;
      if (clk2 && !p2) cnt2++;
      p1 = clk1; p2 = clk2; pany = clk1 | clk2;
      if (done) begin
        exp_t e;
        done_cnt++;
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("ch1_pulses", cnt1, (e.ch == 1) ? e.n : 0);
          check("ch2_pulses", cnt2, (e.ch == 2) ? e.n : 0);
          check("frame_cnt_at_done", int'(frame_cnt), e.fc);
        end
        cnt1 = 0; cnt2 = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_f0();
    @(posedge clk); #2 f0 = 1'b0;
    repeat (3) @(posedge clk);
    #2 f0 = 1'b1;
  endtask

  task automatic pulse_c4();
    @(posedge clk); #2 c4 = 1'b0;
    repeat (3) @(posedge clk);
    #2 c4 = 1'b1;
  endtask

  task automatic wr_len(input logic [7:0] v);
    @(posedge clk); #2 wr = 1'b1; wdata = v;
    @(posedge clk); #2 wr = 1'b0;
  endtask

  task automatic push(input int ch, input int n);
    exp_t e;
    fcm++;
    e.ch = ch; e.n = n; e.fc = fcm;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n0 = done_cnt;
    int i = 0;
    while (done_cnt == n0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    check(tag, int'(done_cnt != n0), 1);
  endtask

  task automatic run_burst(input int ch, input int n, input string tag);
    push(ch, n);
    pulse_f0();
    cyc(8);
    pulse_c4();
    wait_done(n * 4 * HP + 100, tag);
    cyc(5);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset_n = 1'b0; f0 = 1'b1; c4 = 1'b1; req = 2'b00; wr = 1'b0; wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_clk_en1", int'(clk_en1), 0);
    check("rst_clk_en2", int'(clk_en2), 0);
    check("rst_clk1", int'(clk1), 0);
    check("rst_clk2", int'(clk2), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    @(posedge clk); #2 reset_n = 1'b1;
    cyc(4);

    // single-channel burst with reset length
    req = 2'b01;
    push(1, 32);
    pulse_f0();
    cyc(10);
    @(negedge clk);
    check("t1_en1_granted", int'(clk_en1), 1);
    check("t1_en2_idle", int'(clk_en2), 0);
    check("t1_busy", int'(busy), 1);
    pulse_c4();
    wait_done(300, "t1_done_seen");
    cyc(20);
    @(negedge clk);
    check("t1_done_once", done_cnt, 1);
    check("t1_frame_cnt", int'(frame_cnt), 1);
    check("t1_en1_dropped", int'(clk_en1), 0);
    check("t1_idle", int'(busy), 0);

    // round-robin with both requesting
    req = 2'b11;
    run_burst(1, 32, "t2_rr_a");
    run_burst(2, 32, "t2_rr_b");
    run_burst(1, 32, "t2_rr_c");
    @(negedge clk);
    check("t2_frame_cnt", int'(frame_cnt), 4);

    // programmed lengths, including 0 = 256
    req = 2'b01;
    wr_len(8'h05);
    run_burst(1, 5, "t3_len5");
    wr_len(8'h00);
    run_burst(1, 256, "t3_len256");
    wr_len(8'h04);
    push(1, 4);
    pulse_f0();
    cyc(8);
    wr_len(8'h07);
    pulse_c4();
    wait_done(200, "t3_busy_wr");
    cyc(5);

    // c4 timeout
    n0 = done_cnt;
    pulse_f0();
    cyc(500);
    @(negedge clk);
    check("t4_still_waiting", int'(busy), 1);
    check("t4_no_err_yet", int'(err), 0);
    cyc(600);
    @(negedge clk);
    check("t4_err", int'(err), 1);
    check("t4_en1_dropped", int'(clk_en1), 0);
    check("t4_idle", int'(busy), 0);
    check("t4_no_done", done_cnt, n0);
    check("t4_frame_cnt", int'(frame_cnt), fcm);
    wr_len(8'h20);
    @(negedge clk);
    check("t4_err_cleared", int'(err), 0);

    // f0 overrun mid-burst
    n0 = done_cnt;
    push(1, 32);
    pulse_f0();
    cyc(8);
    pulse_c4();
    cyc(20);
    pulse_f0();
    wait_done(300, "t5_done_seen");
    cyc(30);
    @(negedge clk);
    check("t5_err", int'(err), 1);
    check("t5_no_regrant", int'(busy), 0);
    check("t5_one_done", done_cnt, n0 + 1);
    check("t5_en_low", int'(clk_en1 | clk_en2), 0);
    wr_len(8'h0C);
    @(negedge clk);
    check("t5_err_cleared", int'(err), 0);

    // asynchronous reset during pulse 10
    req = 2'b11;
    push(2, 12);
    pulse_f0();
    cyc(8);
    pulse_c4();
    for (int i = 0; i < 200 && cnt2 < 10; i++) @(negedge clk);
    check("t6_reached_pulse10", int'(cnt2 >= 10), 1);
    check("t6_clk2_high", int'(clk2), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_clk_en2", int'(clk_en2), 0);
    check("t6_rst_clk2", int'(clk2), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_frame_cnt", int'(frame_cnt), 0);
    check("t6_rst_err", int'(err), 0);
    sb.delete();
    fcm = 0;
    cyc(3);
    #2 reset_n = 1'b1;
    cyc(3);
    run_burst(1, 32, "t6_post_reset_burst");
    @(negedge clk);
    check("t6_frame_cnt", int'(frame_cnt), 1);
    check("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
